// File: rtl/privmode_nest_if.sv
// privmode_nest_if: M/W-stage signal bundle between pipeline control and the privilege-mode tracker.
//  master (pipeline/driver): StallW, TrapM, TrapToM/HS/VS, mretM, sretM, STATUS_MPP, STATUS_SPP,
//                            MSTATUS_MPV, HSTATUS_SPV, NestClrM
//  slave  (tracker):         NextPrivilegeModeM, NextVirtModeM, PrivilegeModeW, VirtModeW,
//                            NestDepthW, DoubleTrapM, LockedW
//  PRIVMODE_DEBUG_EN adds DebugReqM, dretM, DCSR_PRV, DCSR_V (to tracker) and DebugModeW (from it).
interface privmode_nest_if #(parameter int NEST_W = 4);
  logic StallW, TrapM, TrapToM, TrapToHS, TrapToVS, mretM, sretM;
  logic [1:0] STATUS_MPP;
  logic STATUS_SPP, MSTATUS_MPV, HSTATUS_SPV, NestClrM;
  logic [1:0] NextPrivilegeModeM, PrivilegeModeW;
  logic NextVirtModeM, VirtModeW;
  logic [NEST_W-1:0] NestDepthW;
  logic DoubleTrapM, LockedW;
`ifdef PRIVMODE_DEBUG_EN
  logic DebugReqM, dretM, DCSR_V, DebugModeW;
  logic [1:0] DCSR_PRV;
  modport master(output StallW, TrapM, TrapToM, TrapToHS, TrapToVS, mretM, sretM, STATUS_MPP,
                 STATUS_SPP, MSTATUS_MPV, HSTATUS_SPV, NestClrM, DebugReqM, dretM, DCSR_PRV, DCSR_V,
                 input NextPrivilegeModeM, NextVirtModeM, PrivilegeModeW, VirtModeW, NestDepthW,
                 DoubleTrapM, LockedW, DebugModeW);
  modport slave(input StallW, TrapM, TrapToM, TrapToHS, TrapToVS, mretM, sretM, STATUS_MPP,
                STATUS_SPP, MSTATUS_MPV, HSTATUS_SPV, NestClrM, DebugReqM, dretM, DCSR_PRV, DCSR_V,
                output NextPrivilegeModeM, NextVirtModeM, PrivilegeModeW, VirtModeW, NestDepthW,
                DoubleTrapM, LockedW, DebugModeW);
`else
  modport master(output StallW, TrapM, TrapToM, TrapToHS, TrapToVS, mretM, sretM, STATUS_MPP,
                 STATUS_SPP, MSTATUS_MPV, HSTATUS_SPV, NestClrM,
                 input NextPrivilegeModeM, NextVirtModeM, PrivilegeModeW, VirtModeW, NestDepthW,
                 DoubleTrapM, LockedW);
  modport slave(input StallW, TrapM, TrapToM, TrapToHS, TrapToVS, mretM, sretM, STATUS_MPP,
                STATUS_SPP, MSTATUS_MPV, HSTATUS_SPV, NestClrM,
                output NextPrivilegeModeM, NextVirtModeM, PrivilegeModeW, VirtModeW, NestDepthW,
                DoubleTrapM, LockedW);
`endif
endinterface

// File: rtl/privmode_nest.sv
// privmode_nest: tracks {V, PRV} across traps and returns, counts nested M-mode traps and locks on double trap.
//  clk      in  clock
//  reset_n  in  asynchronous active-low reset
//  bus      privmode_nest_if.slave (pipeline events in, next/current mode, depth, lock out)
//  Optional debug mode (DEBUG state, debug ports) is built when PRIVMODE_DEBUG_EN is defined.
module privmode_nest #(
  parameter bit U_SUP    = 1'b1,
  parameter bit S_SUP    = 1'b1,
  parameter bit H_SUP    = 1'b1,
  parameter int MAX_NEST = 2,
  parameter int NEST_W   = 4
) (
  input logic clk,
  input logic reset_n,
  privmode_nest_if.slave bus
);
`ifdef PRIVMODE_DEBUG_EN
  typedef enum logic [1:0] {RUN, LOCKED, DEBUG} state_t;
  state_t saved_q, saved_d;
`else
  typedef enum logic [1:0] {RUN, LOCKED} state_t;
`endif
  localparam logic [NEST_W-1:0] MAX = NEST_W'(MAX_NEST);
  state_t state_q, state_d;
  logic [1:0] prv_q, prv_d, mpp;
  logic v_q, v_d, dbl, to_m;
  logic [NEST_W-1:0] depth_q, depth_d;
  // Without S-mode every trap lands in M; reserved MPP (and S when absent) returns to U.
  assign to_m = bus.TrapToM | (S_SUP ? 1'b0 : (bus.TrapToHS | bus.TrapToVS));
  assign mpp = (bus.STATUS_MPP == 2'b10 || (!S_SUP && bus.STATUS_MPP == 2'b01)) ? 2'b00 : bus.STATUS_MPP;
  always_comb begin
    state_d = state_q;
    prv_d = prv_q;
    v_d = v_q;
    depth_d = depth_q;
    dbl = 1'b0;
`ifdef PRIVMODE_DEBUG_EN
    saved_d = saved_q;
`endif
    case (state_q)
      RUN: begin
        depth_d = bus.NestClrM ? '0 : depth_q;
        if (bus.TrapM) begin
          prv_d = to_m ? 2'b11 : 2'b01;
          v_d = to_m ? 1'b0 : bus.TrapToVS;
          // A same-cycle nest clear wins over the depth bookkeeping, so no double trap then.
          if (to_m && !bus.NestClrM) begin
            dbl = depth_q == MAX;
            depth_d = dbl ? depth_q : depth_q + NEST_W'(1);
            state_d = dbl ? LOCKED : RUN;
          end
        end else if (bus.mretM) begin
          prv_d = mpp;
          v_d = bus.MSTATUS_MPV & (mpp != 2'b11);
          depth_d = (bus.NestClrM || depth_q == '0) ? '0 : depth_q - NEST_W'(1);
        end else if (bus.sretM && S_SUP) begin
          prv_d = {1'b0, bus.STATUS_SPP};
          v_d = v_q | bus.HSTATUS_SPV;
        end
      end
      LOCKED: begin
        prv_d = 2'b11;
        v_d = 1'b0;
        depth_d = bus.NestClrM ? '0 : depth_q;
        state_d = bus.NestClrM ? RUN : LOCKED;
      end
`ifdef PRIVMODE_DEBUG_EN
      DEBUG: begin
        prv_d = bus.dretM ? bus.DCSR_PRV : prv_q;
        v_d = bus.dretM ? bus.DCSR_V : v_q;
        state_d = bus.dretM ? saved_q : DEBUG;
      end
`endif
      default: state_d = RUN;
    endcase
`ifdef PRIVMODE_DEBUG_EN
    // Debug entry preempts every other event and remembers where to return.
    if (bus.DebugReqM && state_q != DEBUG) begin
      saved_d = state_q;
      state_d = DEBUG;
      prv_d = 2'b11;
      v_d = 1'b0;
      depth_d = depth_q;
      dbl = 1'b0;
    end
`endif
    if (!U_SUP) prv_d = 2'b11;
    if (!H_SUP) v_d = 1'b0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      prv_q <= 2'b11;
      v_q <= 1'b0;
      depth_q <= '0;
`ifdef PRIVMODE_DEBUG_EN
      saved_q <= RUN;
`endif
    end else if (!bus.StallW) begin
      state_q <= state_d;
      prv_q <= prv_d;
      v_q <= v_d;
      depth_q <= depth_d;
`ifdef PRIVMODE_DEBUG_EN
      saved_q <= saved_d;
`endif
    end
  end
  assign bus.NextPrivilegeModeM = prv_d;
  assign bus.NextVirtModeM = v_d;
  assign bus.PrivilegeModeW = prv_q;
  assign bus.VirtModeW = v_q;
  assign bus.NestDepthW = depth_q;
  assign bus.DoubleTrapM = dbl;
  assign bus.LockedW = state_q == LOCKED;
`ifdef PRIVMODE_DEBUG_EN
  assign bus.DebugModeW = state_q == DEBUG;
`endif
endmodule

// File: tb/tb_privmode_nest.sv
// tb_privmode_nest: directed and random checks of privmode_nest against a mode/depth reference model.
module tb_privmode_nest;
  localparam int MAX_NEST = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int m_prv, m_v, m_depth;
  bit m_lock;
  privmode_nest_if #(.NEST_W(4)) pif ();
  privmode_nest dut (.clk(clk), .reset_n(reset_n), .bus(pif));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_prv = 3;
    m_v = 0;
    m_depth = 0;
    m_lock = 0;
  endtask
  task automatic check_w(input string tag);
    check({tag, "_prv"}, pif.PrivilegeModeW, m_prv);
    check({tag, "_v"}, pif.VirtModeW, m_v);
    check({tag, "_depth"}, pif.NestDepthW, m_depth);
    check({tag, "_lock"}, pif.LockedW, m_lock);
  endtask
  // tgt: 0 = M, 1 = HS, 2 = VS
  task automatic cycle(input bit trap, input int tgt, input bit mret, input bit sret, input logic [1:0] mpp,
                       input bit spp, input bit mpv, input bit spv, input bit clr, input bit stall);
    int np, nv, nd, m;
    bit nl, dt;
    @(negedge clk);
    pif.TrapM = trap;
    pif.TrapToM = trap && tgt == 0;
    pif.TrapToHS = trap && tgt == 1;
    pif.TrapToVS = trap && tgt == 2;
    pif.mretM = mret;
    pif.sretM = sret;
    pif.STATUS_MPP = mpp;
    pif.STATUS_SPP = spp;
    pif.MSTATUS_MPV = mpv;
    pif.HSTATUS_SPV = spv;
    pif.NestClrM = clr;
    pif.StallW = stall;
    np = m_prv; nv = m_v; nd = m_depth; nl = m_lock; dt = 0;
    if (m_lock) begin
      np = 3; nv = 0;
      if (clr) begin nd = 0; nl = 0; end
    end else begin
      if (clr) nd = 0;
      if (trap) begin
        np = (tgt == 0) ? 3 : 1;
        nv = (tgt == 2) ? 1 : 0;
        if (tgt == 0 && !clr) begin
          if (m_depth == MAX_NEST) begin dt = 1; nl = 1; end
          else nd = m_depth + 1;
        end
      end else if (mret) begin
        m = (mpp == 2) ? 0 : int'(mpp);
        np = m;
        nv = (mpv && m != 3) ? 1 : 0;
        if (!clr && m_depth > 0) nd = m_depth - 1;
      end else if (sret) begin
        np = spp;
        nv = m_v ? 1 : int'(spv);
      end
    end
    #1;
    check("next_prv", pif.NextPrivilegeModeM, np);
    check("next_v", pif.NextVirtModeM, nv);
    check("double_trap", pif.DoubleTrapM, dt);
    @(posedge clk);
    if (!stall) begin m_prv = np; m_v = nv; m_depth = nd; m_lock = nl; end
    #1;
    check_w("w");
  endtask
  task automatic idle(input bit stall);
    cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, stall);
  endtask
  task automatic async_reset();
    @(negedge clk);
    pif.TrapM = 1; pif.TrapToM = 1; pif.TrapToHS = 0; pif.TrapToVS = 0;
    pif.mretM = 0; pif.sretM = 0; pif.NestClrM = 0; pif.StallW = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_w("rst_async");
    check("rst_next_prv", pif.NextPrivilegeModeM, 3);
    pif.StallW = 1;
    @(posedge clk);
    #1;
    check_w("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    pif.TrapM = 0; pif.TrapToM = 0; pif.StallW = 0;
  endtask
  initial begin
    pif.StallW = 0; pif.TrapM = 0; pif.TrapToM = 0; pif.TrapToHS = 0; pif.TrapToVS = 0;
    pif.mretM = 0; pif.sretM = 0; pif.STATUS_MPP = 0; pif.STATUS_SPP = 0;
    pif.MSTATUS_MPV = 0; pif.HSTATUS_SPV = 0; pif.NestClrM = 0;
`ifdef PRIVMODE_DEBUG_EN
    pif.DebugReqM = 0; pif.dretM = 0; pif.DCSR_PRV = 0; pif.DCSR_V = 0;
`endif
    model_reset();
    #12;
    check_w("reset");
    reset_n = 1'b1;
    // reset mid-trap after some nesting
    cycle(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    async_reset();
    // from U: TrapToVS, sret SPP=0, TrapToM
    cycle(0, 0, 1, 0, 2'b00, 0, 1, 0, 0, 0);
    check("t2_u", pif.PrivilegeModeW, 0);
    cycle(1, 2, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    check("t2_vs_prv", pif.PrivilegeModeW, 1);
    check("t2_vs_v", pif.VirtModeW, 1);
    cycle(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    check("t2_sret_prv", pif.PrivilegeModeW, 0);
    check("t2_sret_v", pif.VirtModeW, 1);
    cycle(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    check("t2_depth", pif.NestDepthW, 1);
    // three back-to-back M traps from depth 0 -> double trap
    cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    check("t3_clr", pif.NestDepthW, 0);
    cycle(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    check("t3_depth2", pif.NestDepthW, 2);
    cycle(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    check("t3_locked", pif.LockedW, 1);
    check("t3_depth_sat", pif.NestDepthW, 2);
    // locked: returns and traps ignored, clear unlocks
    cycle(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    check("t4_prv", pif.PrivilegeModeW, 3);
    cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    check("t4_unlock", pif.LockedW, 0);
    cycle(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    check("t4_mret_u", pif.PrivilegeModeW, 0);
    // trap beats mret, stall holds
    cycle(1, 1, 1, 0, 2'b11, 0, 0, 0, 0, 0);
    check("t5_trap_wins", pif.PrivilegeModeW, 1);
    cycle(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
    check("t5_stall", pif.PrivilegeModeW, 1);
    cycle(0, 0, 1, 0, 2'b10, 0, 1, 0, 0, 0);
    check("t5_mpp_rsvd", pif.PrivilegeModeW, 0);
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 75) async_reset();
      else cycle($urandom_range(0, 9) < 3, $urandom_range(0, 2), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0,
                 $urandom_range(0, 6) == 0);
    end
`ifdef PRIVMODE_DEBUG_EN
    cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    repeat (3) cycle(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    pif.TrapM = 0; pif.TrapToM = 0; pif.DebugReqM = 1;
    @(posedge clk);
    #1;
    check("dbg_prv", pif.PrivilegeModeW, 3);
    check("dbg_mode", pif.DebugModeW, 1);
    @(negedge clk);
    pif.DebugReqM = 0; pif.dretM = 1; pif.DCSR_PRV = 0; pif.DCSR_V = 1;
    @(posedge clk);
    #1;
    check("dret_prv", pif.PrivilegeModeW, 0);
    check("dret_v", pif.VirtModeW, 1);
    check("dret_lock", pif.LockedW, 1);
    @(negedge clk);
    pif.dretM = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
